// File: rtl/otrip_if.sv
// Register-side bundle of the overvoltage trip-select sequencer: requested code and
// enable in, one-hot tap select and status out.
interface otrip_if;
    logic        ena;
    logic [3:0]  otrip;
    logic [15:0] otrip_decoded;
    logic        settled;
    logic        busy;

    modport master (
        output ena, otrip,
        input  otrip_decoded, settled, busy
    );

    modport slave (
        input  ena, otrip,
        output otrip_decoded, settled, busy
    );
endinterface

// File: rtl/otrip_sequencer.sv
// Break-before-make sequencer for the resistor-string tap mux with a settle timer.
// Optional OTRIP_SYNC_EN adds 2-flop synchronizers on ena/otrip (+2 cycles latency).
module otrip_sequencer #(
    parameter int SETTLE_CYCLES = 64,
    parameter int BREAK_CYCLES  = 2
) (
    input logic   clk,
    input logic   rst,
    otrip_if.slave bus
);

    localparam int CNT_MAX = (SETTLE_CYCLES > BREAK_CYCLES) ? SETTLE_CYCLES - 1 : BREAK_CYCLES - 1;
    localparam int CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] BREAK_LOAD  = CW'(BREAK_CYCLES - 1);

    typedef enum logic [1:0] {OFF, BREAK, SETTLE, STABLE} state_t;

    state_t        state;
    logic [3:0]    code;
    logic [CW-1:0] cnt;
    logic [15:0]   decoded;
    logic          settled_q;
    logic          busy_q;
    logic          ena_s;
    logic [3:0]    otrip_s;

`ifdef OTRIP_SYNC_EN
    logic       ena_m;
    logic [3:0] otrip_m;

    always_ff @(posedge clk) begin
        if (rst) begin
            ena_m   <= 1'b0;
            ena_s   <= 1'b0;
            otrip_m <= 4'd0;
            otrip_s <= 4'd0;
        end else begin
            ena_m   <= bus.ena;
            ena_s   <= ena_m;
            otrip_m <= bus.otrip;
            otrip_s <= otrip_m;
        end
    end
`else
    assign ena_s   = bus.ena;
    assign otrip_s = bus.otrip;
`endif

    function automatic logic [15:0] one_hot(input logic [3:0] c);
        return 16'h0001 << c;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= OFF;
            code      <= 4'd0;
            cnt       <= '0;
            decoded   <= 16'h0000;
            settled_q <= 1'b0;
            busy_q    <= 1'b0;
        end else if (!ena_s) begin
            state     <= OFF;
            cnt       <= '0;
            decoded   <= 16'h0000;
            settled_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    code      <= otrip_s;
                    decoded   <= one_hot(otrip_s);
                    cnt       <= SETTLE_LOAD;
                    settled_q <= 1'b0;
                    busy_q    <= 1'b1;
                    state     <= SETTLE;
                end
                SETTLE: begin
                    // A code change wins over a settle that would complete on the same edge.
                    if (otrip_s != code) begin
                        decoded <= 16'h0000;
                        cnt     <= BREAK_LOAD;
                        state   <= BREAK;
                    end else if (cnt == '0) begin
                        settled_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state     <= STABLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STABLE: begin
                    if (otrip_s != code) begin
                        decoded   <= 16'h0000;
                        settled_q <= 1'b0;
                        busy_q    <= 1'b1;
                        cnt       <= BREAK_LOAD;
                        state     <= BREAK;
                    end
                end
                BREAK: begin
                    // Only the code present at expiry matters; intermediate values are dropped.
                    if (cnt == '0) begin
                        code    <= otrip_s;
                        decoded <= one_hot(otrip_s);
                        cnt     <= SETTLE_LOAD;
                        state   <= SETTLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    decoded   <= 16'h0000;
                    settled_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state     <= OFF;
                end
            endcase
        end
    end

    assign bus.otrip_decoded = decoded;
    assign bus.settled       = settled_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_otrip_sequencer.sv
// Randomized + directed bench for otrip_sequencer against a timestamp-based reference model.
module tb_otrip_sequencer;

    localparam int S = 64;
    localparam int B = 2;
`ifdef OTRIP_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    otrip_if bus ();

    otrip_sequencer #(.SETTLE_CYCLES(S), .BREAK_CYCLES(B)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: tap is either off, breaking since m_mark, or driven since m_mark.
    int         t = 0;
    bit         m_on  = 1'b0;
    bit         m_brk = 1'b0;
    logic [3:0] m_code = 4'd0;
    int         m_mark = 0;
    logic [1:0] p_e = '0;
    logic [3:0] p_o [2] = '{4'd0, 4'd0};
    logic [15:0] prev_dec = 16'h0000;

    task automatic model_edge(input logic r, input logic e, input logic [3:0] o);
        logic       ee;
        logic [3:0] oo;
        t++;
        if (LAT == 2) begin
            ee = p_e[1];
            oo = p_o[1];
            if (r) begin
                p_e = '0;
                p_o[0] = 4'd0;
                p_o[1] = 4'd0;
            end else begin
                p_e    = {p_e[0], e};
                p_o[1] = p_o[0];
                p_o[0] = o;
            end
        end else begin
            ee = e;
            oo = o;
        end
        if (r || !ee) begin
            m_on = 1'b0;
        end else if (!m_on) begin
            m_on = 1'b1; m_brk = 1'b0; m_code = oo; m_mark = t;
        end else if (m_brk) begin
            if (t - m_mark == B) begin
                m_brk = 1'b0; m_code = oo; m_mark = t;
            end
        end else if (oo != m_code) begin
            m_brk = 1'b1; m_mark = t;
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [3:0] o);
        logic [15:0] x_dec;
        logic        x_set;
        logic        x_busy;
        logic [15:0] d;
        @(negedge clk);
        rst       = r;
        bus.ena   = e;
        bus.otrip = o;
        @(posedge clk);
        model_edge(r, e, o);
        #1;
        if (!m_on) begin
            x_dec = 16'h0000; x_set = 1'b0; x_busy = 1'b0;
        end else if (m_brk) begin
            x_dec = 16'h0000; x_set = 1'b0; x_busy = 1'b1;
        end else begin
            x_set  = (t - m_mark) >= S;
            x_dec  = 16'h0001 << m_code;
            x_busy = !x_set;
        end
        d = bus.otrip_decoded;
        check("model_dec", 32'(d), 32'(x_dec));
        check("model_settled", 32'(bus.settled), 32'(x_set));
        check("model_busy", 32'(bus.busy), 32'(x_busy));
        check("onehot_or_zero", 32'($countones(d) <= 1), 32'd1);
        check("break_before_make", 32'(prev_dec == 16'h0 || d == 16'h0 || d == prev_dec), 32'd1);
        check("settled_busy_excl", 32'(bus.settled && bus.busy), 32'd0);
        prev_dec = d;
    endtask

    initial begin
        logic       r_en;
        logic [3:0] r_code;
        rst = 1'b1; bus.ena = 1'b0; bus.otrip = 4'd0;
        repeat (3) step(1'b1, 1'b0, 4'd0);
        check("reset_dec", 32'(bus.otrip_decoded), 32'h0);
        check("reset_settled", 32'(bus.settled), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);

        // Enable from OFF with code 5.
        for (int i = 0; i <= LAT + S + 2; i++) begin
            step(1'b0, 1'b1, 4'd5);
            if (i == LAT) begin
                check("en_onehot", 32'(bus.otrip_decoded), 32'h0020);
                check("en_busy", 32'(bus.busy), 32'd1);
            end
            if (i == LAT + S - 1) check("en_not_yet_settled", 32'(bus.settled), 32'd0);
            if (i == LAT + S) begin
                check("en_settled", 32'(bus.settled), 32'd1);
                check("en_busy_low", 32'(bus.busy), 32'd0);
            end
        end

        // Code change 5 -> 12 in STABLE.
        for (int i = 0; i <= LAT + B + S + 2; i++) begin
            step(1'b0, 1'b1, 4'd12);
            if (i == LAT || i == LAT + 1) check("chg_open", 32'(bus.otrip_decoded), 32'h0);
            if (i == LAT + B) check("chg_new_tap", 32'(bus.otrip_decoded), 32'h1000);
            if (i == LAT + B + S - 1) check("chg_not_settled", 32'(bus.settled), 32'd0);
            if (i == LAT + B + S) check("chg_settled", 32'(bus.settled), 32'd1);
        end

        // Change 3 -> 9 part way through the settle of 3.
        repeat (LAT + B + 10) step(1'b0, 1'b1, 4'd3);
        for (int i = 0; i <= LAT + B + S + 1; i++) begin
            step(1'b0, 1'b1, 4'd9);
            if (i == LAT + B + S - 1) check("abandon_full_settle", 32'(bus.settled), 32'd0);
        end
        check("abandon_tap", 32'(bus.otrip_decoded), 32'h0200);
        check("abandon_settled", 32'(bus.settled), 32'd1);

        // Toggle 7 -> 2 -> 7 inside the break.
        step(1'b0, 1'b1, 4'd7);
        step(1'b0, 1'b1, 4'd2);
        repeat (LAT + B + S + 2) step(1'b0, 1'b1, 4'd7);
        check("toggle_tap", 32'(bus.otrip_decoded), 32'h0080);
        check("toggle_settled", 32'(bus.settled), 32'd1);

        // Drop ena during SETTLE, then reset during BREAK.
        repeat (LAT + B + 5) step(1'b0, 1'b1, 4'd4);
        repeat (LAT + 1) step(1'b0, 1'b0, 4'd4);
        check("dis_dec", 32'(bus.otrip_decoded), 32'h0);
        check("dis_busy", 32'(bus.busy), 32'd0);
        repeat (LAT + S + 1) step(1'b0, 1'b1, 4'd4);
        check("reen_settled", 32'(bus.settled), 32'd1);
        repeat (LAT + 1) step(1'b0, 1'b1, 4'd6);
        step(1'b1, 1'b1, 4'd6);
        check("rst_brk_dec", 32'(bus.otrip_decoded), 32'h0);
        check("rst_brk_busy", 32'(bus.busy), 32'd0);

        // Randomized traffic.
        r_en = 1'b1;
        r_code = 4'd6;
        for (int i = 0; i < 3000; i++) begin
            if (r_en && $urandom_range(0, 149) == 0) r_en = 1'b0;
            else if (!r_en && $urandom_range(0, 9) == 0) r_en = 1'b1;
            if ($urandom_range(0, 24) == 0) r_code = 4'($urandom_range(0, 15));
            step(1'(($urandom_range(0, 399) == 0)), r_en, r_code);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/otrip_sequencer.md
# otrip_sequencer

Sequences the analog trip-select lines that drive the resistor-string tap mux of the overvoltage detector. It turns a 4-bit trip code into the 16-bit one-hot `otrip_decoded` bus and enforces break-before-make on code changes, so no two taps are ever shorted. It also runs a settle timer so the downstream comparator knows when `vin` is valid. It sits between the digital register interface and the resistor string/mux, in the `dvdd` domain.

## Interface
- `SETTLE_CYCLES`, 64: cycles the tap must be held before `settled` asserts; legal range 1..1023.
- `BREAK_CYCLES`, 2: cycles all taps are open between two codes; legal range 1..15.
- `clk`  input  1  digital clock.
- `rst`  input  1  reset. One clock; reset is synchronous and active-high.
- `ena`  input  1  block enable; when low, all taps are open.
- `otrip`  input  4  requested trip code; 0 selects the highest-ratio tap.
- `otrip_decoded`  output  16  one-hot tap select; bit n is high for code n. All-zero means open.
- `settled`  output  1  tap is stable and the `vin` seen downstream is valid.
- `busy`  output  1  high in BREAK and SETTLE.

## Operation
- Internal state: state (OFF, BREAK, SETTLE, STABLE), latched 4-bit `code`, and a down-counter wide enough for `SETTLE_CYCLES-1`.
- OFF: all outputs are 0.
  - `ena`=1 → latch `otrip`, drive its one-hot code, load the counter, go to SETTLE.
- SETTLE: one-hot(`code`) driven, `busy`=1.
  - Counter decrements each cycle; at 0 → STABLE.
  - `otrip`≠`code` → BREAK. The settle is abandoned, and a new settle restarts from full after the break.
- STABLE: one-hot(`code`) driven, `settled`=1, `busy`=0.
  - `otrip`≠`code` → BREAK.
- BREAK: `otrip_decoded`=0, `settled`=0, `busy`=1, counter runs for `BREAK_CYCLES`.
  - On expiry, latch the current `otrip`, which is the latest value; intermediate codes are ignored. Drive it, reload the counter, go to SETTLE.
  - A change back to the old code during BREAK still completes the break and the settle.
- `ena`=0 in any state → OFF on the next edge, with all outputs 0. This takes priority over code changes.
- `rst` has priority over everything. Reset mid-operation → OFF with outputs 0, regardless of state.
- Invariant: `otrip_decoded` is always all-zero or exactly one-hot. It never goes directly from one one-hot value to a different one.
- `settled` and `busy` are never both 1.

## Timing
- Reset values: `otrip_decoded`=16'h0000, `settled`=0, `busy`=0, state OFF, `code`=0.
- All outputs are registered.
- Enable from OFF: with `ena`=1 sampled at edge k:
  - one-hot valid and `busy`=1 from edge k;
  - `settled`=1 and `busy`=0 from edge k+`SETTLE_CYCLES`.
- Code change in STABLE or SETTLE, sampled at edge k:
  - all-zero from edge k;
  - new one-hot from edge k+`BREAK_CYCLES`;
  - `settled` from edge k+`BREAK_CYCLES`+`SETTLE_CYCLES`.
- Disable sampled at edge k → all outputs 0 from edge k.
- Simultaneous `ena` rise and code value: the code sampled at the same edge is used.

## Configuration
- `OTRIP_SYNC_EN` defined:
  - `ena` and `otrip` each pass through a 2-flop synchronizer before the state machine, and are reset to 0.
  - Every input-to-output latency above grows by exactly 2 cycles.
  - Used when the register interface is asynchronous to `clk`.
- `OTRIP_SYNC_EN` undefined: inputs are sampled directly, with the latencies stated above.

## Test plan
All scenarios use the defaults (`SETTLE_CYCLES`=64, `BREAK_CYCLES`=2) and `OTRIP_SYNC_EN` off unless noted.
- Reset then `ena`=1, `otrip`=5 at edge 0 → `otrip_decoded`=16'h0020 from edge 0, `busy`=1. Then `settled`=1 and `busy`=0 at edge 64.
- In STABLE with code 5, set `otrip`=12 at edge k → 16'h0000 at k and k+1, 16'h1000 at k+2, `settled` at k+66. No cycle has two bits set.
- During SETTLE of code 3, change to 9 at cycle 10 of the settle → break of 2 cycles, then a full 64-cycle settle on 16'h0200.
- In BREAK, toggle `otrip` 7→2→7 → the break completes, 16'h0080 is driven, and a full settle follows.
- Drop `ena` during SETTLE, and assert `rst` during BREAK → outputs 0 at the next edge, state OFF. Re-enabling restarts from full.
- With `OTRIP_SYNC_EN`, repeat the first scenario → one-hot at edge 2, `settled` at edge 66.
